// File: rtl/proc_tinyrv1_pkg.sv
// Shared definitions for the TinyRV1 single-cycle core.
// Contents: datapath widths, RV32 opcode/funct3/funct7 constants, CSR numbers,
// control enums, the decoded-control payload struct and the immediate generator.
package proc_tinyrv1_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned NREGS  = 32;

    // Major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // funct3 / funct7 selectors
    localparam logic [2:0] F3_ADD   = 3'b000;
    localparam logic [2:0] F3_WORD  = 3'b010;
    localparam logic [2:0] F3_BNE   = 3'b001;
    localparam logic [2:0] F3_JALR  = 3'b000;
    localparam logic [2:0] F3_CSRRW = 3'b001;
    localparam logic [2:0] F3_CSRRS = 3'b010;
    localparam logic [6:0] F7_ADD   = 7'b0000000;
    localparam logic [6:0] F7_MUL   = 7'b0000001;

    // CSR numbers
    localparam logic [11:0] CSR_IN0  = 12'hFC2;
    localparam logic [11:0] CSR_IN1  = 12'hFC3;
    localparam logic [11:0] CSR_IN2  = 12'hFC4;
    localparam logic [11:0] CSR_OUT0 = 12'h7C2;
    localparam logic [11:0] CSR_OUT1 = 12'h7C3;
    localparam logic [11:0] CSR_OUT2 = 12'h7C4;

    typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_type_e;
    typedef enum logic [0:0] {ALU_ADD, ALU_MUL} alu_op_e;
    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_CSR} wb_sel_e;
    typedef enum logic [1:0] {PC_SEQ, PC_BNE, PC_JAL, PC_JR} pc_sel_e;

    // Decoded control for one instruction
    typedef struct packed {
        logic      reg_we;
        alu_op_e   alu_op;
        imm_type_e imm_type;
        logic      use_imm;
        wb_sel_e   wb_sel;
        pc_sel_e   pc_sel;
        logic      dmem_val;
        logic      dmem_wr;
        logic      csr_wr;
    } ctrl_t;

    // Sign-extended immediate from instruction bits [31:7]
    function automatic logic [XLEN-1:0] imm_gen(input logic [31:7] ib, input imm_type_e t);
        logic [XLEN-1:0] imm;
        case (t)
            IMM_I:   imm = {{20{ib[31]}}, ib[31:20]};
            IMM_S:   imm = {{20{ib[31]}}, ib[31:25], ib[11:7]};
            IMM_B:   imm = {{19{ib[31]}}, ib[31], ib[7], ib[30:25], ib[11:8], 1'b0};
            IMM_J:   imm = {{11{ib[31]}}, ib[31], ib[19:12], ib[20], ib[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/proc_regfile_2r1w.sv
// 32x32 register file: two combinational read ports, one write port at posedge.
// x0 reads as zero and ignores writes. Contents are not reset.
// Ports: clk; raddr0_i/rdata0_o, raddr1_i/rdata1_o (reads); we_i, waddr_i, wdata_i (write).
module proc_regfile_2r1w
    import proc_tinyrv1_pkg::*;
(
    input  logic              clk,
    input  logic [REG_AW-1:0] raddr0_i,
    output logic [XLEN-1:0]   rdata0_o,
    input  logic [REG_AW-1:0] raddr1_i,
    output logic [XLEN-1:0]   rdata1_o,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [XLEN-1:0]   wdata_i
);

    logic [XLEN-1:0] regs_q [NREGS];

    // Reads see the pre-edge value even when the same register is being written
    assign rdata0_o = (raddr0_i == '0) ? '0 : regs_q[raddr0_i];
    assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];

    always_ff @(posedge clk) begin
        if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/proc_scycle_core.sv
// Single-cycle TinyRV1 core: fetch, decode, execute and commit one instruction per cycle.
// Ports: clk, rst (sync, active-low); imemreq_val/addr, imemresp_data (comb fetch);
// dmemreq_val/type/addr/wdata, dmemresp_rdata (comb data access); in0..in2 (CSR inputs);
// out0..out2 (registered CSR outputs); trace_val/addr/data (commit trace).
// Build option: define PROC_TRACE_EN to enable the trace port; otherwise it is tied to 0.
module proc_scycle_core
    import proc_tinyrv1_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imemreq_val,
    output logic [31:0] imemreq_addr,
    input  logic [31:0] imemresp_data,
    output logic        dmemreq_val,
    output logic        dmemreq_type,
    output logic [31:0] dmemreq_addr,
    output logic [31:0] dmemreq_wdata,
    input  logic [31:0] dmemresp_rdata,
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    output logic [31:0] out0,
    output logic [31:0] out1,
    output logic [31:0] out2,
    output logic        trace_val,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data
);

    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   out0_q, out0_d, out1_q, out1_d, out2_q, out2_d;
    logic [XLEN-1:0]   instr;
    logic [6:0]        opcode, funct7;
    logic [2:0]        funct3;
    logic [REG_AW-1:0] rd, rs1, rs2;
    logic [11:0]       csr;
    ctrl_t             ctrl;
    logic [XLEN-1:0]   rs1_data, rs2_data, imm, opb, alu_res;
    logic [XLEN-1:0]   pc_plus4, pc_target, csr_rdata, wb_data;
    logic              csr_in_hit, csr_out_hit;

    // Field extraction
    assign instr  = imemresp_data;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];
    assign csr    = instr[31:20];

    // CSR decode and input-CSR read mux
    always_comb begin
        csr_rdata  = '0;
        csr_in_hit = 1'b0;
        case (csr)
            CSR_IN0: begin csr_in_hit = 1'b1; csr_rdata = in0; end
            CSR_IN1: begin csr_in_hit = 1'b1; csr_rdata = in1; end
            CSR_IN2: begin csr_in_hit = 1'b1; csr_rdata = in2; end
            default: ;
        endcase
    end

    assign csr_out_hit = (csr == CSR_OUT0) || (csr == CSR_OUT1) || (csr == CSR_OUT2);

    // Decoder: anything not matched exactly falls through as a nop
    always_comb begin
        ctrl.reg_we   = 1'b0;
        ctrl.alu_op   = ALU_ADD;
        ctrl.imm_type = IMM_I;
        ctrl.use_imm  = 1'b0;
        ctrl.wb_sel   = WB_ALU;
        ctrl.pc_sel   = PC_SEQ;
        ctrl.dmem_val = 1'b0;
        ctrl.dmem_wr  = 1'b0;
        ctrl.csr_wr   = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (funct3 == F3_ADD && funct7 == F7_ADD) begin
                    ctrl.reg_we = 1'b1;
                end else if (funct3 == F3_ADD && funct7 == F7_MUL) begin
                    ctrl.reg_we = 1'b1;
                    ctrl.alu_op = ALU_MUL;
                end
            end
            OPC_OPIMM: begin
                if (funct3 == F3_ADD) begin
                    ctrl.reg_we  = 1'b1;
                    ctrl.use_imm = 1'b1;
                end
            end
            OPC_LOAD: begin
                if (funct3 == F3_WORD) begin
                    ctrl.reg_we   = 1'b1;
                    ctrl.use_imm  = 1'b1;
                    ctrl.wb_sel   = WB_MEM;
                    ctrl.dmem_val = 1'b1;
                end
            end
            OPC_STORE: begin
                if (funct3 == F3_WORD) begin
                    ctrl.imm_type = IMM_S;
                    ctrl.use_imm  = 1'b1;
                    ctrl.dmem_val = 1'b1;
                    ctrl.dmem_wr  = 1'b1;
                end
            end
            OPC_BRANCH: begin
                if (funct3 == F3_BNE) begin
                    ctrl.imm_type = IMM_B;
                    ctrl.pc_sel   = PC_BNE;
                end
            end
            OPC_JAL: begin
                ctrl.reg_we   = 1'b1;
                ctrl.imm_type = IMM_J;
                ctrl.wb_sel   = WB_PC4;
                ctrl.pc_sel   = PC_JAL;
            end
            OPC_JALR: begin
                // Only the jr form (rd=x0, imm=0) is part of the ISA
                if (funct3 == F3_JALR && rd == '0 && csr == '0) begin
                    ctrl.pc_sel = PC_JR;
                end
            end
            OPC_SYSTEM: begin
                // csrr = csrrs rd,csr,x0 ; csrw = csrrw x0,csr,rs1
                if (funct3 == F3_CSRRS && rs1 == '0 && csr_in_hit) begin
                    ctrl.reg_we = 1'b1;
                    ctrl.wb_sel = WB_CSR;
                end else if (funct3 == F3_CSRRW && rd == '0 && csr_out_hit) begin
                    ctrl.csr_wr = 1'b1;
                end
            end
            default: ;
        endcase
    end

    proc_regfile_2r1w u_regfile (
        .clk      (clk),
        .raddr0_i (rs1),
        .rdata0_o (rs1_data),
        .raddr1_i (rs2),
        .rdata1_o (rs2_data),
        .we_i     (rst && ctrl.reg_we),
        .waddr_i  (rd),
        .wdata_i  (wb_data)
    );

    // Execute
    assign imm       = imm_gen(instr[31:7], ctrl.imm_type);
    assign opb       = ctrl.use_imm ? imm : rs2_data;
    assign alu_res   = (ctrl.alu_op == ALU_MUL) ? (rs1_data * opb) : (rs1_data + opb);
    assign pc_plus4  = pc_q + 32'd4;
    assign pc_target = pc_q + imm;

    // Writeback mux
    always_comb begin
        wb_data = alu_res;
        case (ctrl.wb_sel)
            WB_MEM:  wb_data = dmemresp_rdata;
            WB_PC4:  wb_data = pc_plus4;
            WB_CSR:  wb_data = csr_rdata;
            default: wb_data = alu_res;
        endcase
    end

    // Next-PC mux
    always_comb begin
        pc_d = pc_plus4;
        case (ctrl.pc_sel)
            PC_BNE:  if (rs1_data != rs2_data) pc_d = pc_target;
            PC_JAL:  pc_d = pc_target;
            PC_JR:   pc_d = rs1_data;
            default: pc_d = pc_plus4;
        endcase
    end

    // Output CSR update
    always_comb begin
        out0_d = out0_q;
        out1_d = out1_q;
        out2_d = out2_q;
        if (ctrl.csr_wr) begin
            case (csr)
                CSR_OUT0: out0_d = rs1_data;
                CSR_OUT1: out1_d = rs1_data;
                CSR_OUT2: out2_d = rs1_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q   <= RESET_PC;
            out0_q <= '0;
            out1_q <= '0;
            out2_q <= '0;
        end else begin
            pc_q   <= pc_d;
            out0_q <= out0_d;
            out1_q <= out1_d;
            out2_q <= out2_d;
        end
    end

    // Memory ports
    assign imemreq_val   = rst;
    assign imemreq_addr  = pc_q;
    assign dmemreq_val   = rst && ctrl.dmem_val;
    assign dmemreq_type  = ctrl.dmem_wr;
    assign dmemreq_addr  = alu_res;
    assign dmemreq_wdata = rs2_data;

    assign out0 = out0_q;
    assign out1 = out1_q;
    assign out2 = out2_q;

`ifdef PROC_TRACE_EN
    assign trace_val  = rst;
    assign trace_addr = pc_q;
    assign trace_data = (ctrl.reg_we && rd != '0) ? wb_data : '0;
`else
    assign trace_val  = 1'b0;
    assign trace_addr = '0;
    assign trace_data = '0;
`endif

endmodule

// File: tb/tb_proc_scycle_core.sv
// Bench for proc_scycle_core: a directed program checked against a table of
// per-cycle expectations, then a random program checked against an
// instruction-level model of the ISA.
module tb_proc_scycle_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        imemreq_val;
    logic [31:0] imemreq_addr;
    logic [31:0] imemresp_data;
    logic        dmemreq_val;
    logic        dmemreq_type;
    logic [31:0] dmemreq_addr;
    logic [31:0] dmemreq_wdata;
    logic [31:0] dmemresp_rdata;
    logic [31:0] in0, in1, in2;
    logic [31:0] out0, out1, out2;
    logic        trace_val;
    logic [31:0] trace_addr;
    logic [31:0] trace_data;

    always #5 clk = ~clk;

    proc_scycle_core #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imemreq_val    (imemreq_val),
        .imemreq_addr   (imemreq_addr),
        .imemresp_data  (imemresp_data),
        .dmemreq_val    (dmemreq_val),
        .dmemreq_type   (dmemreq_type),
        .dmemreq_addr   (dmemreq_addr),
        .dmemreq_wdata  (dmemreq_wdata),
        .dmemresp_rdata (dmemresp_rdata),
        .in0            (in0),
        .in1            (in1),
        .in2            (in2),
        .out0           (out0),
        .out1           (out1),
        .out2           (out2),
        .trace_val      (trace_val),
        .trace_addr     (trace_addr),
        .trace_data     (trace_data)
    );

    // Combinational memories (1 KB each, address wraps)
    logic [31:0] imem [256];
    logic [31:0] dmem [256];
    assign imemresp_data  = imem[imemreq_addr[9:2]];
    assign dmemresp_rdata = dmem[dmemreq_addr[9:2]];
    always @(posedge clk) begin
        if (rst && dmemreq_val && dmemreq_type) dmem[dmemreq_addr[9:2]] <= dmemreq_wdata;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_trace(input logic [31:0] exp_addr, input logic chk_data, input logic [31:0] exp_data);
`ifdef PROC_TRACE_EN
        chk("trace_val", 32'(trace_val), 32'd1);
        chk("trace_addr", trace_addr, exp_addr);
        if (chk_data) chk("trace_data", trace_data, exp_data);
`else
        chk("trace_val_off", 32'(trace_val), 32'd0);
        chk("trace_addr_off", trace_addr, 32'd0);
        if (chk_data || exp_addr != 32'd0) chk("trace_data_off", trace_data, 32'd0);
`endif
    endtask

    // Instruction encoders
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {im, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] i_add(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
        return enc_r(7'h00, b, a, 3'd0, rd, 7'h33);
    endfunction
    function automatic logic [31:0] i_mul(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
        return enc_r(7'h01, b, a, 3'd0, rd, 7'h33);
    endfunction
    function automatic logic [31:0] i_addi(input logic [4:0] rd, input logic [4:0] a, input logic [11:0] im);
        return enc_i(im, a, 3'd0, rd, 7'h13);
    endfunction
    function automatic logic [31:0] i_lw(input logic [4:0] rd, input logic [4:0] a, input logic [11:0] im);
        return enc_i(im, a, 3'd2, rd, 7'h03);
    endfunction
    function automatic logic [31:0] i_sw(input logic [4:0] src, input logic [4:0] a, input logic [11:0] im);
        return {im[11:5], src, a, 3'd2, im[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] i_bne(input logic [4:0] a, input logic [4:0] b, input logic [12:0] im);
        return {im[12], im[10:5], b, a, 3'd1, im[4:1], im[11], 7'h63};
    endfunction
    function automatic logic [31:0] i_jal(input logic [4:0] rd, input logic [20:0] im);
        return {im[20], im[10:1], im[11], im[19:12], rd, 7'h6F};
    endfunction
    function automatic logic [31:0] i_jr(input logic [4:0] a);
        return enc_i(12'h000, a, 3'd0, 5'd0, 7'h67);
    endfunction
    function automatic logic [31:0] i_csrr(input logic [4:0] rd, input logic [11:0] c);
        return enc_i(c, 5'd0, 3'd2, rd, 7'h73);
    endfunction
    function automatic logic [31:0] i_csrw(input logic [11:0] c, input logic [4:0] a);
        return enc_i(c, a, 3'd1, 5'd0, 7'h73);
    endfunction

    // Directed vectors: per committed instruction, the expected observable outputs
    typedef struct {
        logic [31:0] pc;
        logic        dval;
        logic        dtype;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic        tchk;
        logic [31:0] tdata;
        logic [31:0] out0;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic [31:0] pc, input logic dval, input logic dtype, input logic [31:0] daddr,
                                input logic [31:0] dwdata, input logic tchk, input logic [31:0] tdata,
                                input logic [31:0] o0);
        vec_t v;
        v.pc = pc; v.dval = dval; v.dtype = dtype; v.daddr = daddr; v.dwdata = dwdata;
        v.tchk = tchk; v.tdata = tdata; v.out0 = o0;
        return v;
    endfunction

    // Reference model state
    logic [31:0] m_regs [32];
    logic [31:0] m_mem  [256];
    logic [31:0] m_out  [3];
    logic [31:0] m_pc;

    function automatic logic [31:0] rv(input logic [4:0] r);
        return (r == 5'd0) ? 32'd0 : m_regs[r];
    endfunction

    // Execute one instruction in the model, compare the DUT's cycle, advance a clock
    task automatic model_check_step();
        logic [31:0] ins, a, b, nxt, wv, da, immi, imms, immb, immj;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] c;
        logic        wr, dv, st;
        int          ow;
        ins  = imem[m_pc[9:2]];
        op   = ins[6:0];  rd = ins[11:7]; f3 = ins[14:12];
        rs1  = ins[19:15]; rs2 = ins[24:20]; f7 = ins[31:25]; c = ins[31:20];
        immi = {{20{ins[31]}}, ins[31:20]};
        imms = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        immb = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        immj = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        a = rv(rs1); b = rv(rs2);
        nxt = m_pc + 32'd4; wr = 1'b0; wv = 32'd0; dv = 1'b0; st = 1'b0; da = 32'd0; ow = -1;
        case (op)
            7'h33: if (f3 == 3'd0 && f7 == 7'h00) begin wr = 1'b1; wv = a + b; end
                   else if (f3 == 3'd0 && f7 == 7'h01) begin wr = 1'b1; wv = a * b; end
            7'h13: if (f3 == 3'd0) begin wr = 1'b1; wv = a + immi; end
            7'h03: if (f3 == 3'd2) begin dv = 1'b1; da = a + immi; wr = 1'b1; wv = m_mem[da[9:2]]; end
            7'h23: if (f3 == 3'd2) begin dv = 1'b1; st = 1'b1; da = a + imms; end
            7'h63: if (f3 == 3'd1 && a != b) nxt = m_pc + immb;
            7'h6F: begin wr = 1'b1; wv = m_pc + 32'd4; nxt = m_pc + immj; end
            7'h67: if (f3 == 3'd0 && rd == 5'd0 && c == 12'd0) nxt = a;
            7'h73: begin
                if (f3 == 3'd2 && rs1 == 5'd0) begin
                    if (c == 12'hFC2) begin wr = 1'b1; wv = in0; end
                    if (c == 12'hFC3) begin wr = 1'b1; wv = in1; end
                    if (c == 12'hFC4) begin wr = 1'b1; wv = in2; end
                end else if (f3 == 3'd1 && rd == 5'd0) begin
                    if (c == 12'h7C2) ow = 0;
                    if (c == 12'h7C3) ow = 1;
                    if (c == 12'h7C4) ow = 2;
                end
            end
            default: ;
        endcase
        chk("pc", imemreq_addr, m_pc);
        chk("imemreq_val", 32'(imemreq_val), 32'd1);
        chk("dmemreq_val", 32'(dmemreq_val), 32'(dv));
        if (dv) begin
            chk("dmemreq_type", 32'(dmemreq_type), 32'(st));
            chk("dmemreq_addr", dmemreq_addr, da);
        end
        if (st) chk("dmemreq_wdata", dmemreq_wdata, b);
        chk("out0", out0, m_out[0]);
        chk("out1", out1, m_out[1]);
        chk("out2", out2, m_out[2]);
        chk_trace(m_pc, wr && rd != 5'd0, wv);
        if (wr && rd != 5'd0) m_regs[rd] = wv;
        if (st) m_mem[da[9:2]] = b;
        if (ow >= 0) m_out[ow] = a;
        m_pc = nxt;
        @(posedge clk); @(negedge clk); #1;
    endtask

    function automatic logic [4:0] rr();
        return 5'($urandom_range(0, 7));
    endfunction

    function automatic logic [31:0] rand_instr();
        int off;
        off = ($urandom_range(0, 1) != 0 ? 1 : -1) * int'($urandom_range(1, 16)) * 4;
        case ($urandom_range(0, 11))
            0:  return i_add(rr(), rr(), rr());
            1:  return i_mul(rr(), rr(), rr());
            2:  return i_addi(rr(), rr(), 12'($urandom));
            3:  return i_lw(rr(), rr(), 12'($urandom));
            4:  return i_sw(rr(), rr(), 12'($urandom));
            5:  return i_bne(rr(), rr(), 13'(off));
            6:  return i_jal(rr(), 21'(off));
            7:  return i_jr(rr());
            8:  return i_csrr(rr(), 12'(12'hFC2 + 12'($urandom_range(0, 3))));
            9:  return i_csrw(12'(12'h7C1 + 12'($urandom_range(0, 3))), rr());
            10: return {25'($urandom), 7'h0B};
            default: return enc_r(7'h20, rr(), rr(), 3'd0, rr(), 7'h33);
        endcase
    endfunction

    initial begin
        rst = 1'b0;
        in0 = 32'h7; in1 = $urandom; in2 = $urandom;
        for (int i = 0; i < 256; i++) begin imem[i] = i_addi(5'd9, 5'd0, 12'd1); dmem[i] = 32'd0; end
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        dmem[32'h100 >> 2] = 32'h0000_CAFE;

        imem[32'h00 >> 2] = i_addi(5'd1, 5'd0, 12'd5);
        imem[32'h04 >> 2] = i_add(5'd2, 5'd1, 5'd1);
        imem[32'h08 >> 2] = i_addi(5'd3, 5'd0, 12'h100);
        imem[32'h0C >> 2] = i_lw(5'd4, 5'd3, 12'd0);
        imem[32'h10 >> 2] = i_sw(5'd1, 5'd3, 12'd4);
        imem[32'h14 >> 2] = i_lw(5'd5, 5'd3, 12'd4);
        imem[32'h18 >> 2] = i_bne(5'd1, 5'd0, 13'd8);
        imem[32'h1C >> 2] = i_addi(5'd9, 5'd0, 12'd99);
        imem[32'h20 >> 2] = i_jal(5'd1, 21'd12);
        imem[32'h24 >> 2] = i_bne(5'd0, 5'd0, 13'd8);
        imem[32'h28 >> 2] = i_jal(5'd0, 21'd16);
        imem[32'h2C >> 2] = i_jr(5'd1);
        imem[32'h38 >> 2] = i_csrr(5'd6, 12'hFC2);
        imem[32'h3C >> 2] = i_mul(5'd7, 5'd6, 5'd6);
        imem[32'h40 >> 2] = i_csrw(12'h7C2, 5'd7);
        imem[32'h44 >> 2] = i_addi(5'd0, 5'd0, 12'd9);
        imem[32'h48 >> 2] = i_sw(5'd0, 5'd3, 12'd8);
        imem[32'h4C >> 2] = i_addi(5'd8, 5'd0, 12'hFFF);
        imem[32'h50 >> 2] = i_addi(5'd9, 5'd0, 12'd2);
        imem[32'h54 >> 2] = i_mul(5'd10, 5'd8, 5'd9);
        imem[32'h58 >> 2] = i_sw(5'd10, 5'd3, 12'd0);
        imem[32'h5C >> 2] = i_jal(5'd0, 21'd0);

        //             pc        dval  type  daddr       dwdata        tchk  tdata         out0
        vecs[0]  = mk(32'h00, 1'b0, 1'b0, 32'h0,     32'h0,        1'b1, 32'h5,        32'h0);
        vecs[1]  = mk(32'h04, 1'b0, 1'b0, 32'h0,     32'h0,        1'b1, 32'hA,        32'h0);
        vecs[2]  = mk(32'h08, 1'b0, 1'b0, 32'h0,     32'h0,        1'b1, 32'h100,      32'h0);
        vecs[3]  = mk(32'h0C, 1'b1, 1'b0, 32'h100,   32'h0,        1'b1, 32'hCAFE,     32'h0);
        vecs[4]  = mk(32'h10, 1'b1, 1'b1, 32'h104,   32'h5,        1'b0, 32'h0,        32'h0);
        vecs[5]  = mk(32'h14, 1'b1, 1'b0, 32'h104,   32'h0,        1'b1, 32'h5,        32'h0);
        vecs[6]  = mk(32'h18, 1'b0, 1'b0, 32'h0,     32'h0,        1'b0, 32'h0,        32'h0);
        vecs[7]  = mk(32'h20, 1'b0, 1'b0, 32'h0,     32'h0,        1'b1, 32'h24,       32'h0);
        vecs[8]  = mk(32'h2C, 1'b0, 1'b0, 32'h0,     32'h0,        1'b0, 32'h0,        32'h0);
        vecs[9]  = mk(32'h24, 1'b0, 1'b0, 32'h0,     32'h0,        1'b0, 32'h0,        32'h0);
        vecs[10] = mk(32'h28, 1'b0, 1'b0, 32'h0,     32'h0,        1'b0, 32'h0,        32'h0);
        vecs[11] = mk(32'h38, 1'b0, 1'b0, 32'h0,     32'h0,        1'b1, 32'h7,        32'h0);
        vecs[12] = mk(32'h3C, 1'b0, 1'b0, 32'h0,     32'h0,        1'b1, 32'h31,       32'h0);
        vecs[13] = mk(32'h40, 1'b0, 1'b0, 32'h0,     32'h0,        1'b0, 32'h0,        32'h0);
        vecs[14] = mk(32'h44, 1'b0, 1'b0, 32'h0,     32'h0,        1'b0, 32'h0,        32'h31);
        vecs[15] = mk(32'h48, 1'b1, 1'b1, 32'h108,   32'h0,        1'b0, 32'h0,        32'h31);
        vecs[16] = mk(32'h4C, 1'b0, 1'b0, 32'h0,     32'h0,        1'b1, 32'hFFFFFFFF, 32'h31);
        vecs[17] = mk(32'h50, 1'b0, 1'b0, 32'h0,     32'h0,        1'b1, 32'h2,        32'h31);
        vecs[18] = mk(32'h54, 1'b0, 1'b0, 32'h0,     32'h0,        1'b1, 32'hFFFFFFFE, 32'h31);
        vecs[19] = mk(32'h58, 1'b1, 1'b1, 32'h100,   32'hFFFFFFFE, 1'b0, 32'h0,        32'h31);
        vecs[20] = mk(32'h5C, 1'b0, 1'b0, 32'h0,     32'h0,        1'b0, 32'h0,        32'h31);
        vecs[21] = mk(32'h5C, 1'b0, 1'b0, 32'h0,     32'h0,        1'b0, 32'h0,        32'h31);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_imemreq_val", 32'(imemreq_val), 32'd0);
        chk("rst_dmemreq_val", 32'(dmemreq_val), 32'd0);
        chk("rst_pc", imemreq_addr, 32'h0);
        chk("rst_out0", out0, 32'd0);
        chk("rst_out1", out1, 32'd0);
        chk("rst_out2", out2, 32'd0);
        chk("rst_trace_val", 32'(trace_val), 32'd0);

        // Directed program
        rst = 1'b1; #1;
        for (int i = 0; i < NVEC; i++) begin
            if (i > 0) begin @(posedge clk); @(negedge clk); #1; end
            chk($sformatf("v%0d_pc", i), imemreq_addr, vecs[i].pc);
            chk($sformatf("v%0d_dval", i), 32'(dmemreq_val), 32'(vecs[i].dval));
            if (vecs[i].dval) begin
                chk($sformatf("v%0d_dtype", i), 32'(dmemreq_type), 32'(vecs[i].dtype));
                chk($sformatf("v%0d_daddr", i), dmemreq_addr, vecs[i].daddr);
                if (vecs[i].dtype) chk($sformatf("v%0d_dwdata", i), dmemreq_wdata, vecs[i].dwdata);
            end
            chk($sformatf("v%0d_out0", i), out0, vecs[i].out0);
            chk_trace(vecs[i].pc, vecs[i].tchk, vecs[i].tdata);
        end
        chk("mem_0x104", dmem[32'h104 >> 2], 32'h5);

        // Mid-program reset with out0 non-zero
        rst = 1'b0; #1;
        chk("midrst_imemreq_val", 32'(imemreq_val), 32'd0);
        chk("midrst_trace_val_now", 32'(trace_val), 32'd0);
        @(posedge clk); @(negedge clk); #1;
        chk("midrst_pc", imemreq_addr, 32'h0);
        chk("midrst_out0", out0, 32'd0);
        chk("midrst_out1", out1, 32'd0);
        chk("midrst_out2", out2, 32'd0);
        chk("midrst_trace_val", 32'(trace_val), 32'd0);

        // Random program against the model; held in reset over a store first
        in0 = $urandom; in1 = $urandom; in2 = $urandom;
        for (int i = 0; i < 256; i++) begin
            dmem[i] = $urandom;
            m_mem[i] = dmem[i];
            imem[i] = rand_instr();
        end
        imem[0] = i_sw(5'd0, 5'd0, 12'd0);
        for (int k = 1; k < 8; k++) imem[k] = i_addi(5'(k), 5'd0, 12'($urandom));
        #1;
        chk("rst_store_dmemreq_val", 32'(dmemreq_val), 32'd0);
        chk("rst_store_pc", imemreq_addr, 32'h0);
        for (int i = 0; i < 3; i++) m_out[i] = 32'd0;
        m_pc = 32'h0;
        rst = 1'b1; #1;
        for (int s = 0; s < 400; s++) model_check_step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
